// File: rtl/router_fifo_nport.sv
// Address-routed 1-to-NUM_OUT splitter with an independent DEPTH-entry FIFO
// per output port; valid/ready handshakes on both sides.
module router_fifo_nport #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 4,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(NUM_OUT),
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  input  logic [AW-1:0]                 din_addr,
  output logic                          din_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] dout,
  output logic [NUM_OUT-1:0]            dout_valid,
  input  logic [NUM_OUT-1:0]            dout_ready,
  output logic [NUM_OUT*CW-1:0]         fill
);

  logic [DATA_WIDTH-1:0] mem  [NUM_OUT][DEPTH];
  logic [PW-1:0]         wptr [NUM_OUT];
  logic [PW-1:0]         rptr [NUM_OUT];
  logic [CW-1:0]         cnt  [NUM_OUT];
  logic                  push;
  logic [NUM_OUT-1:0]    push_sel;
  logic [NUM_OUT-1:0]    pop;

  // Ready looks only at the addressed port's occupancy, so a pop on a full
  // port never lets a word through in the same cycle.
  assign din_ready = (cnt[din_addr] != CW'(DEPTH));
  assign push      = din_valid & din_ready;

  always_comb begin
    push_sel = '0;
    pop      = '0;
    for (int unsigned p = 0; p < NUM_OUT; p++) begin
      push_sel[p] = push && (din_addr == AW'(p));
      pop[p]      = (cnt[p] != '0) && dout_ready[p];
    end
  end

  always_comb begin
    dout       = '0;
    dout_valid = '0;
    fill       = '0;
    for (int unsigned p = 0; p < NUM_OUT; p++) begin
      dout_valid[p]        = (cnt[p] != '0);
      fill[p*CW +: CW]     = cnt[p];
      if (cnt[p] != '0)
        dout[p*DATA_WIDTH +: DATA_WIDTH] = mem[p][rptr[p]];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned p = 0; p < NUM_OUT; p++) begin
        wptr[p] <= '0;
        rptr[p] <= '0;
        cnt[p]  <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_OUT; p++) begin
        if (push_sel[p]) wptr[p] <= wptr[p] + PW'(1);
        if (pop[p])      rptr[p] <= rptr[p] + PW'(1);
        case ({push_sel[p], pop[p]})
          2'b10:   cnt[p] <= cnt[p] + CW'(1);
          2'b01:   cnt[p] <= cnt[p] - CW'(1);
          default: cnt[p] <= cnt[p];
        endcase
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[din_addr][wptr[din_addr]] <= din;
  end

endmodule
